// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and lane helpers for the MEM-stage load/store requester.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BE_W   = XLEN / 8;
  localparam int unsigned BE8_W  = 2 * BE_W;
  localparam int unsigned XLEN2  = 2 * XLEN;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } lsu_state_t;

  // Captured request; addr is word-aligned, be8/wdata span both possible word accesses.
  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [1:0]        off;
    logic              split;
    logic              err;
    logic [XLEN-1:0]   addr;
    logic [BE8_W-1:0]  be8;
    logic [XLEN2-1:0]  wdata;
  } lsu_req_t;

  function automatic logic [BE_W-1:0] base_be(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: base_be = 4'b0001;
      F3_H, F3_HU: base_be = 4'b0011;
      default:     base_be = 4'b1111;
    endcase
  endfunction

  function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
    if (we) f3_illegal = (funct3 > F3_W);
    else    f3_illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shifts the {hi,lo} read words down to the access offset and sign/zero-extends the result.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] hi,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result_c
);

  logic [XLEN-1:0] x;

  always_comb begin
    x = XLEN'({hi, lo} >> {off, 3'b000});
    case (funct3)
      F3_B:    result_c = {{(XLEN-8){x[7]}}, x[7:0]};
      F3_BU:   result_c = {{(XLEN-8){1'b0}}, x[7:0]};
      F3_H:    result_c = {{(XLEN-16){x[15]}}, x[15:0]};
      F3_HU:   result_c = {{(XLEN-16){1'b0}}, x[15:0]};
      default: result_c = x;
    endcase
  end

endmodule

// File: rtl/lsu_mem_requester.sv
// MEM-stage load/store initiator: word-granular req/gnt/rvalid accesses with optional
// split of misaligned halfword/word accesses into two consecutive word accesses.
module lsu_mem_requester
  import lsu_pkg::*;
#(
  parameter bit          MISALIGN_EN = 1'b1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t        state_q, state_d;
  lsu_req_t          rq_q, rq_d, cap;
  logic [XLEN-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic [XLEN-1:0]   load_c;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

  logic [XLEN-1:0]   wmask;

  // Request decode: lane-shifted byte enables and store data for both word accesses.
  always_comb begin
    case (req_funct3)
      F3_B:    wmask = 32'h0000_00FF;
      F3_H:    wmask = 32'h0000_FFFF;
      default: wmask = 32'hFFFF_FFFF;
    endcase
    cap        = '0;
    cap.we     = req_we;
    cap.funct3 = req_funct3;
    cap.off    = req_addr[1:0];
    cap.addr   = {req_addr[ADDR_W-1:2], 2'b00};
    cap.be8    = BE8_W'(base_be(req_funct3)) << req_addr[1:0];
    cap.wdata  = XLEN2'(req_wdata & wmask) << {req_addr[1:0], 3'b000};
    cap.split  = |cap.be8[BE8_W-1:BE_W];
    cap.err    = f3_illegal(req_we, req_funct3) || (cap.split && !MISALIGN_EN);
  end

  // Next-state and captured data.
  always_comb begin
    state_d = state_q;
    rq_d    = rq_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rq_d    = cap;
          lo_d    = '0;
          hi_d    = '0;
          state_d = cap.err ? RESP : ISSUE0;
        end
      end
      ISSUE0: if (mem_gnt) state_d = WAIT0;
      WAIT0: begin
        if (mem_rvalid) begin
          lo_d    = mem_rdata;
          state_d = rq_q.split ? ISSUE1 : RESP;
        end
      end
      ISSUE1: if (mem_gnt) state_d = WAIT1;
      WAIT1: begin
        if (mem_rvalid) begin
          hi_d    = mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_load_align u_load_align (
    .lo       (lo_d),
    .hi       (hi_d),
    .off      (rq_d.off),
    .funct3   (rq_d.funct3),
    .result_c (load_c)
  );

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    resp_err_d   = resp_valid_d && rq_d.err;
    resp_rdata_d = (resp_valid_d && !rq_d.err && !rq_d.we) ? load_c : '0;
    mem_req_d    = (state_d == ISSUE0) || (state_d == ISSUE1);
    mem_we_d     = mem_req_d && rq_d.we;
    mem_addr_d   = '0;
    mem_be_d     = '0;
    mem_wdata_d  = '0;
    if (state_d == ISSUE0) begin
      mem_addr_d  = rq_d.addr;
      mem_be_d    = rq_d.be8[BE_W-1:0];
      mem_wdata_d = rq_d.wdata[XLEN-1:0];
    end else if (state_d == ISSUE1) begin
      mem_addr_d  = rq_d.addr + XLEN'(4);
      mem_be_d    = rq_d.be8[BE8_W-1:BE_W];
      mem_wdata_d = rq_d.wdata[XLEN2-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rq_q         <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rq_q         <= rq_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
